// File: rtl/minisys_io_pkg.sv
// Shared IO offsets and RAM wait-state FSM encoding for the minisys data-side bridge.
package minisys_io_pkg;

   localparam logic [11:0] SW_OFS    = 12'h000;
   localparam logic [11:0] RES_OFS   = 12'h010;
   localparam logic [11:0] TIMER_OFS = 12'h040;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } ram_state_t;

endpackage

// File: rtl/minisys_io_bridge_if.sv
// CPU data-side bus: address/store data/strobes in, load data and stall out.
interface minisys_io_bridge_if;

   logic [31:0] address;
   logic [31:0] write_data;
   logic        memwrite;
   logic        memread;
   logic [31:0] read_data;
   logic        stall;

   modport master (
      output address, write_data, memwrite, memread,
      input  read_data, stall
   );

   modport slave (
      input  address, write_data, memwrite, memread,
      output read_data, stall
   );

endinterface

// File: rtl/minisys_io_debounce.sv
// One switch bit: two-flop synchroniser followed by a consecutive-sample debounce counter.
module io_debounce #(
   parameter int DB_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic dout
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   logic          sync1_q;
   logic          sync2_q;
   logic [CW-1:0] cnt_q;

   // Bring the raw switch into the clock domain.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
      end
   end

   // Count samples that disagree with the debounced value; any agreement restarts the count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         dout  <= 1'b0;
      end else if (sync2_q == dout) begin
         cnt_q <= '0;
      end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
         cnt_q <= '0;
         dout  <= sync2_q;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/minisys_io_bridge.sv
// Data-side bridge for the minisys CPU: data RAM with wait states, debounced switches,
// result output registers. Optional free-running cycle timer at IO offset 0x040 when
// MINISYS_IO_TIMER_EN is defined.
module minisys_io_bridge
   import minisys_io_pkg::*;
#(
   parameter int          SW_W      = 4,
   parameter int          RES_CH    = 1,
   parameter int          RAM_DEPTH = 1024,
   parameter int          RAM_WAIT  = 1,
   parameter int          DB_CYCLES = 16,
   parameter logic [19:0] IO_BASE   = 20'hFFFFF
) (
   input  logic                  clock,
   input  logic                  reset,
   minisys_io_bridge_if.slave    bus,
   input  logic [SW_W-1:0]       switch,
   output logic [32*RES_CH-1:0]  result
);

   // state | meaning
   // IDLE  | no RAM access in flight; a new RAM request starts here
   // WAIT  | counting down wait states, CPU stalled
   // DONE  | access completes: store commits, load data valid, stall released

   localparam int         AW        = $clog2(RAM_DEPTH);
   localparam logic [3:0] WAIT_LOAD = 4'(RAM_WAIT - 1);

   logic          io_sel;
   logic          ram_req;
   logic          io_wr;
   logic [11:0]   off_w;
   logic [AW-1:0] ram_idx;

   assign io_sel  = (bus.address[31:12] == IO_BASE);
   assign ram_req = !io_sel && (bus.memread || bus.memwrite);
   assign io_wr   = io_sel && bus.memwrite;
   assign off_w   = {bus.address[11:2], 2'b00};
   assign ram_idx = bus.address[AW+1:2];

   logic [SW_W-1:0] sw_db;

   for (genvar i = 0; i < SW_W; i++) begin : g_db
      io_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
         .clock (clock),
         .reset (reset),
         .din   (switch[i]),
         .dout  (sw_db[i])
      );
   end

   ram_state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       ram_we;
   logic       ram_rd_ok;
   logic       stall_raw;

   // Wait-state FSM state and down-counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, stall and RAM strobes.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_raw = 1'b0;
      ram_we    = 1'b0;
      ram_rd_ok = 1'b0;
      case (state_q)
         IDLE: begin
            if (ram_req) begin
               if (RAM_WAIT == 0) begin
                  ram_we    = bus.memwrite;
                  ram_rd_ok = 1'b1;
               end else begin
                  stall_raw = 1'b1;
                  cnt_d     = WAIT_LOAD;
                  state_d   = WAIT;
               end
            end
         end
         WAIT: begin
            stall_raw = 1'b1;
            if (cnt_q == 4'd0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            ram_we    = ram_req && bus.memwrite;
            ram_rd_ok = ram_req;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset releases the CPU immediately, even mid-access.
   assign bus.stall = stall_raw & reset;

   logic [31:0] ram_q [RAM_DEPTH];

   // Data RAM store port; no store can land while reset is held.
   always_ff @(posedge clock) begin
      if (ram_we && reset) begin
         ram_q[ram_idx] <= bus.write_data;
      end
   end

   logic [31:0] res_q [RES_CH];

   // Result channel registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < RES_CH; k++) res_q[k] <= '0;
      end else if (io_wr) begin
         for (int k = 0; k < RES_CH; k++) begin
            if (off_w == RES_OFS + 12'(4 * k)) res_q[k] <= bus.write_data;
         end
      end
   end

   for (genvar k = 0; k < RES_CH; k++) begin : g_res
      assign result[32*k +: 32] = res_q[k];
   end

`ifdef MINISYS_IO_TIMER_EN
   logic [31:0] timer_q;

   // Free-running cycle counter; a write clears it and takes priority over counting.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         timer_q <= '0;
      end else if (io_wr && off_w == TIMER_OFS) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_q + 32'd1;
      end
   end
`endif

   logic [31:0] io_rdata;

   // IO read decode.
   always_comb begin
      io_rdata = '0;
      if (off_w == SW_OFS) io_rdata = 32'(sw_db);
      for (int k = 0; k < RES_CH; k++) begin
         if (off_w == RES_OFS + 12'(4 * k)) io_rdata = res_q[k];
      end
`ifdef MINISYS_IO_TIMER_EN
      if (off_w == TIMER_OFS) io_rdata = timer_q;
`endif
   end

   // Load data back to the register file; stores and idle cycles return zero.
   always_comb begin
      bus.read_data = '0;
      if (bus.memread && !bus.memwrite) begin
         if (io_sel)         bus.read_data = io_rdata;
         else if (ram_rd_ok) bus.read_data = ram_q[ram_idx];
      end
   end

endmodule
